// File: rtl/layer_lut_seq_if.sv
//==============================================================================
// Module   : layer_lut_seq_if
// Brief    : Stream, configuration and status bundle for layer_lut_seq.
//            LAYER_LUT_SEQ_READBACK_EN adds the cfg_re / cfg_rdata pair.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface layer_lut_seq_if #(
    parameter int NEURONS  = 8,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2
);
    localparam int ADDR_W = $clog2(NEURONS) + IN_BITS;

    logic [NEURONS*IN_BITS-1:0]  in_vec;
    logic                        in_valid;
    logic                        in_ready;
    logic [NEURONS*OUT_BITS-1:0] out_vec;
    logic                        out_valid;
    logic                        out_ready;
    logic                        cfg_we;
    logic [ADDR_W-1:0]           cfg_addr;
    logic [OUT_BITS-1:0]         cfg_wdata;
    logic                        cfg_ready;
    logic                        busy;
`ifdef LAYER_LUT_SEQ_READBACK_EN
    logic                        cfg_re;
    logic [OUT_BITS-1:0]         cfg_rdata;

    modport master (
        output in_vec, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata, cfg_re,
        input  in_ready, out_vec, out_valid, cfg_ready, busy, cfg_rdata
    );
    modport slave (
        input  in_vec, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata, cfg_re,
        output in_ready, out_vec, out_valid, cfg_ready, busy, cfg_rdata
    );
`else
    modport master (
        output in_vec, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_vec, out_valid, cfg_ready, busy
    );
    modport slave (
        input  in_vec, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_vec, out_valid, cfg_ready, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/layer_lut_seq.sv
//==============================================================================
// Module   : layer_lut_seq
// Brief    : Time-multiplexed LUT layer; NEURONS truth tables share one memory
//            and are read one neuron per cycle. Optional table readback port
//            enabled by macro LAYER_LUT_SEQ_READBACK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module layer_lut_seq #(
    parameter int NEURONS  = 8,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2
) (
    input  wire            clk,
    input  wire            rst,
    layer_lut_seq_if.slave bus
);
    localparam int c_NW     = $clog2(NEURONS);
    localparam int c_ADDR_W = c_NW + IN_BITS;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;
    localparam logic [c_NW-1:0] c_LAST = c_NW'(NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [NEURONS*IN_BITS-1:0]  r_in_vec;
    logic [c_NW-1:0]             r_cnt;
    logic [c_NW-1:0]             r_wr_idx;
    logic                        r_rd_vld;
    logic                        r_reads_done;
    logic [OUT_BITS-1:0]         r_rdata;
    logic [NEURONS*OUT_BITS-1:0] r_out_vec;
    logic                        r_out_valid;
    logic [OUT_BITS-1:0]         r_table [c_DEPTH];

    logic                        w_idle;
    logic                        w_cfg_ok;
    logic                        w_cfg_wr;
    logic [IN_BITS-1:0]          w_in_k;
    logic [c_ADDR_W-1:0]         w_rd_addr;

    assign w_idle    = (r_state == S_IDLE);
    assign w_cfg_wr  = bus.cfg_we && w_idle && w_cfg_ok;
    assign w_in_k    = r_in_vec[r_cnt*IN_BITS +: IN_BITS];
    assign w_rd_addr = {r_cnt, w_in_k};

    // Neuron field needs a range check only when NEURONS is not a power of two.
    generate
        if ((1 << c_NW) == NEURONS) begin : g_cfg_full
            assign w_cfg_ok = 1'b1;
        end else begin : g_cfg_range
            assign w_cfg_ok = (int'(bus.cfg_addr[c_ADDR_W-1 -: c_NW]) < NEURONS);
        end
    endgenerate

    // Table has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_table[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_vec     <= '0;
            r_cnt        <= '0;
            r_wr_idx     <= '0;
            r_rd_vld     <= 1'b0;
            r_reads_done <= 1'b0;
            r_rdata      <= '0;
            r_out_vec    <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_vec     <= bus.in_vec;
                        r_cnt        <= '0;
                        r_rd_vld     <= 1'b0;
                        r_reads_done <= 1'b0;
                        r_state      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Read stage: one row per cycle, counter parks on the last neuron.
                    if (!r_reads_done) begin
                        r_rdata  <= r_table[w_rd_addr];
                        r_wr_idx <= r_cnt;
                        r_rd_vld <= 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_reads_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_rd_vld <= 1'b0;
                    end
                    // Write-back stage trails the read by one cycle.
                    if (r_rd_vld) begin
                        r_out_vec[r_wr_idx*OUT_BITS +: OUT_BITS] <= r_rdata;
                        if (r_wr_idx == c_LAST) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.cfg_ready = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.out_vec   = r_out_vec;
    assign bus.out_valid = r_out_valid;

`ifdef LAYER_LUT_SEQ_READBACK_EN
    logic [OUT_BITS-1:0] r_cfg_rdata;

    // A write on the same edge is forwarded so readback reflects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_rdata <= '0;
        end else if (bus.cfg_re && w_idle) begin
            if (w_cfg_wr) begin
                r_cfg_rdata <= bus.cfg_wdata;
            end else if (w_cfg_ok) begin
                r_cfg_rdata <= r_table[bus.cfg_addr];
            end else begin
                r_cfg_rdata <= '0;
            end
        end
    end

    assign bus.cfg_rdata = r_cfg_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_lut_seq.sv
//==============================================================================
// Module   : tb_layer_lut_seq
// Brief    : Self-checking bench for layer_lut_seq against a table-array model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_layer_lut_seq;
    localparam int NEURONS  = 8;
    localparam int IN_BITS  = 4;
    localparam int OUT_BITS = 2;
    localparam int ADDR_W   = $clog2(NEURONS) + IN_BITS;
    localparam int ROWS     = 2 ** IN_BITS;
    localparam int IW       = NEURONS * IN_BITS;
    localparam int OW       = NEURONS * OUT_BITS;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [OUT_BITS-1:0] model [NEURONS][ROWS];

    layer_lut_seq_if #(.NEURONS(NEURONS), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    layer_lut_seq #(.NEURONS(NEURONS), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] expect_of(input logic [IW-1:0] v);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < NEURONS; n++) begin
            r[n*OUT_BITS +: OUT_BITS] = model[n][v[n*IN_BITS +: IN_BITS]];
        end
        return r;
    endfunction

    function automatic void model_wr(input logic [ADDR_W-1:0] a, input logic [OUT_BITS-1:0] d);
        int n;
        int row;
        n   = int'(a) / ROWS;
        row = int'(a) % ROWS;
        if (n < NEURONS) model[n][row] = d;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] v;
        for (int n = 0; n < NEURONS; n++) v[n*IN_BITS +: IN_BITS] = IN_BITS'($urandom);
        return v;
    endfunction

    task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [OUT_BITS-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we    = 1'b0;
        model_wr(a, d);
    endtask

    task automatic load_all(input bit row_pattern);
        for (int n = 0; n < NEURONS; n++) begin
            for (int r = 0; r < ROWS; r++) begin
                cfg_write(ADDR_W'(n * ROWS + r), row_pattern ? OUT_BITS'(r) : '0);
            end
        end
    endtask

    // Wait for out_valid after the accepting edge; returns edges counted.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_eval(input logic [IW-1:0] vec, input int hold, input bit noise, input string tag);
        logic [OW-1:0] exp;
        int lat;
        exp = expect_of(vec);
        bus.in_vec    = vec;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", tag, bus.in_ready);
        end
        tick();
        bus.in_valid = noise;
        if (noise) bus.in_vec = ~vec;
        wait_done(lat);
        checks++;
        if (lat != NEURONS + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, NEURONS + 1);
        end
        checks++;
        if (bus.out_vec !== exp) begin
            errors++;
            $display("FAIL %s out_vec: got %h want %h", tag, bus.out_vec, exp);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (bus.out_vec !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold %0d: out_vec %h valid %b in_ready %b busy %b want %h 1 0 1",
                         tag, h, bus.out_vec, bus.out_valid, bus.in_ready, bus.busy, exp);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after handshake: valid %b in_ready %b busy %b want 0 1 0",
                     tag, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_vec !== '0) begin
            errors++;
            $display("FAIL reset: in_ready %b cfg_ready %b busy %b valid %b out_vec %h want 1 1 0 0 0",
                     bus.in_ready, bus.cfg_ready, bus.busy, bus.out_valid, bus.out_vec);
        end
`ifdef LAYER_LUT_SEQ_READBACK_EN
        checks++;
        if (bus.cfg_rdata !== '0) begin
            errors++;
            $display("FAIL reset cfg_rdata: got %b want 0", bus.cfg_rdata);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_row_pattern();
        load_all(1'b1);
        run_eval({NEURONS{4'hB}}, 0, 1'b0, "row_pattern");
    endtask

    task automatic test_hold();
        load_all(1'b0);
        cfg_write(ADDR_W'(3 * ROWS), 2'b10);
        checks++;
        if (expect_of('0) !== 16'h0080) begin
            errors++;
            $display("FAIL hold model: got %h want 0080", expect_of('0));
        end
        run_eval('0, 5, 1'b1, "hold");
    endtask

    task automatic test_cfg_during_eval();
        logic [IW-1:0] vec;
        logic [OW-1:0] exp;
        int lat;
        vec = rand_vec();
        exp = expect_of(vec);
        bus.in_vec   = vec;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = ADDR_W'(5 * ROWS + int'(vec[5*IN_BITS +: IN_BITS]));
        bus.cfg_wdata = ~model[5][vec[5*IN_BITS +: IN_BITS]];
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready in EVAL: got %b want 0", bus.cfg_ready);
        end
        wait_done(lat);
        bus.cfg_we = 1'b0;
        checks++;
        if (lat != NEURONS + 1 || bus.out_vec !== exp) begin
            errors++;
            $display("FAIL cfg_during_eval: lat %0d out_vec %h want %0d %h", lat, bus.out_vec, NEURONS + 1, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        run_eval(vec, 0, 1'b0, "cfg_during_eval_recheck");
    endtask

    task automatic test_reset_mid_eval();
        bus.in_vec   = rand_vec();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_vec !== '0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_eval: valid %b out_vec %h in_ready %b busy %b want 0 0 1 0",
                     bus.out_valid, bus.out_vec, bus.in_ready, bus.busy);
        end
        run_eval(rand_vec(), 1, 1'b0, "after_reset");
    endtask

    task automatic test_same_edge_cfg();
        logic [IW-1:0] vec;
        logic [OW-1:0] exp;
        int lat;
        vec = rand_vec();
        cfg_write(ADDR_W'(vec[IN_BITS-1:0]), 2'b00);
        model_wr(ADDR_W'(vec[IN_BITS-1:0]), 2'b11);
        exp = expect_of(vec);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = ADDR_W'(vec[IN_BITS-1:0]);
        bus.cfg_wdata = 2'b11;
        bus.in_vec    = vec;
        bus.in_valid  = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (bus.out_vec[1:0] !== 2'b11 || bus.out_vec !== exp) begin
            errors++;
            $display("FAIL same_edge_cfg: got %h want %h", bus.out_vec, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int w = 0; w < 3; w++) cfg_write(ADDR_W'($urandom), OUT_BITS'($urandom));
            run_eval(rand_vec(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] vec;
        logic [OW-1:0] exp;
        int acc [$];
        vec = rand_vec();
        exp = expect_of(vec);
        bus.in_vec    = vec;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4 * (NEURONS + 3) && acc.size() < 3; c++) begin
            if (bus.in_ready === 1'b1) acc.push_back(c);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_vec !== exp) begin
                    errors++;
                    $display("FAIL back_to_back out_vec: got %h want %h", bus.out_vec, exp);
                end
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (acc.size() != 3) begin
            errors++;
            $display("FAIL back_to_back accepts: got %0d want 3", acc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != NEURONS + 3) begin
                    errors++;
                    $display("FAIL back_to_back interval: got %0d want %0d", acc[i] - acc[i-1], NEURONS + 3);
                end
            end
        end
        // Drain the in-flight evaluation.
        repeat (NEURONS + 3) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

`ifdef LAYER_LUT_SEQ_READBACK_EN
    task automatic test_readback();
        bus.cfg_we    = 1'b1;
        bus.cfg_re    = 1'b1;
        bus.cfg_addr  = ADDR_W'('h25);
        bus.cfg_wdata = 2'b01;
        tick();
        bus.cfg_we = 1'b0;
        bus.cfg_re = 1'b0;
        model_wr(ADDR_W'('h25), 2'b01);
        checks++;
        if (bus.cfg_rdata !== 2'b01) begin
            errors++;
            $display("FAIL readback: got %b want 01", bus.cfg_rdata);
        end
        cfg_write(ADDR_W'('h13), 2'b10);
        checks++;
        if (bus.cfg_rdata !== 2'b01) begin
            errors++;
            $display("FAIL readback hold: got %b want 01", bus.cfg_rdata);
        end
        bus.cfg_re   = 1'b1;
        bus.cfg_addr = ADDR_W'('h13);
        tick();
        bus.cfg_re = 1'b0;
        checks++;
        if (bus.cfg_rdata !== 2'b10) begin
            errors++;
            $display("FAIL readback second: got %b want 10", bus.cfg_rdata);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.in_vec    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
`ifdef LAYER_LUT_SEQ_READBACK_EN
        bus.cfg_re    = 1'b0;
`endif
        test_reset();
        test_row_pattern();
        test_hold();
        test_cfg_during_eval();
        test_reset_mid_eval();
        test_same_edge_cfg();
        test_random();
        test_back_to_back();
`ifdef LAYER_LUT_SEQ_READBACK_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
